// File: rtl/sc_bus_pkg.sv
// Shared slow-control bus definitions: field widths, FSM states, error codes.
package sc_bus_pkg;

  localparam int unsigned SC_PORT_W = 16;
  localparam int unsigned SC_ADDR_W = 32;
  localparam int unsigned SC_DATA_W = 32;
  localparam int unsigned SC_ERR_W  = 32;

  // Error word reported when the responder never acknowledges
  localparam logic [SC_ERR_W-1:0] SC_ERR_TIMEOUT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_STROBE   = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_RESP     = 3'd4,
    ST_RELEASE  = 3'd5
  } sc_state_e;

  // Command / bus field bundle presented to the responders
  typedef struct packed {
    logic [SC_PORT_W-1:0] port;
    logic [SC_ADDR_W-1:0] addr;
    logic [SC_ADDR_W-1:0] subaddr;
    logic [SC_DATA_W-1:0] data;
    logic                 op;
  } sc_fields_t;

endpackage

// File: rtl/sc_cmd_initiator.sv
// Slow-control bus initiator: one SC transaction per accepted command,
// returning the responder reply (or a timeout) on a valid/ready response port.
module sc_cmd_initiator
  import sc_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  // command port
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [SC_PORT_W-1:0] cmd_port,
  input  logic [SC_ADDR_W-1:0] cmd_addr,
  input  logic [SC_ADDR_W-1:0] cmd_subaddr,
  input  logic [SC_DATA_W-1:0] cmd_data,
  input  logic                 cmd_op,
  // SC bus
  output logic [SC_PORT_W-1:0] sc_port,
  output logic [SC_ADDR_W-1:0] sc_addr,
  output logic [SC_ADDR_W-1:0] sc_subaddr,
  output logic [SC_DATA_W-1:0] sc_data,
  output logic                 sc_op,
  output logic                 sc_frame,
  output logic                 sc_wr,
  input  logic                 sc_ack,
  input  logic [SC_DATA_W-1:0] sc_rply_data,
  input  logic [SC_ERR_W-1:0]  sc_rply_error,
  // response port
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [SC_DATA_W-1:0] rsp_data,
  output logic [SC_ERR_W-1:0]  rsp_error,
  output logic                 rsp_timeout,
  output logic                 busy
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  sc_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  sc_fields_t           fields_q, fields_d;
  logic                 sc_frame_q, sc_frame_d;
  logic                 sc_wr_q, sc_wr_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [SC_DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [SC_ERR_W-1:0]  rsp_error_q, rsp_error_d;
  logic                 rsp_timeout_q, rsp_timeout_d;
  logic                 busy_q, busy_d;

  // State, counter, captured fields and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      fields_q      <= '0;
      sc_frame_q    <= 1'b0;
      sc_wr_q       <= 1'b0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_error_q   <= '0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fields_q      <= fields_d;
      sc_frame_q    <= sc_frame_d;
      sc_wr_q       <= sc_wr_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
    end
  end

  // Next state, counter and capture logic; outputs decoded from the next state
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fields_d      = fields_q;
    rsp_data_d    = rsp_data_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          fields_d.port    = cmd_port;
          fields_d.addr    = cmd_addr;
          fields_d.subaddr = cmd_subaddr;
          fields_d.data    = cmd_data;
          fields_d.op      = cmd_op;
          state_d          = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (sc_ack) begin
          rsp_data_d    = sc_rply_data;
          rsp_error_d   = sc_rply_error;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end else if (cnt_q == CNT_MAX) begin
          rsp_data_d    = '0;
          rsp_error_d   = SC_ERR_TIMEOUT;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // A responder that never drops ack is abandoned after the timeout
        if (!sc_ack || (cnt_q == CNT_MAX)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    sc_frame_d  = (state_d == ST_SETUP) || (state_d == ST_STROBE) ||
                  (state_d == ST_WAIT_ACK);
    sc_wr_d     = (state_d == ST_STROBE);
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    busy_d      = (state_d != ST_IDLE);
  end

  assign cmd_ready   = cmd_ready_q;
  assign sc_port     = fields_q.port;
  assign sc_addr     = fields_q.addr;
  assign sc_subaddr  = fields_q.subaddr;
  assign sc_data     = fields_q.data;
  assign sc_op       = fields_q.op;
  assign sc_frame    = sc_frame_q;
  assign sc_wr       = sc_wr_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sc_cmd_initiator.sv
// Directed bench for sc_cmd_initiator with a short timeout.
module tb_sc_cmd_initiator;

  localparam int unsigned T = 16;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_port;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_subaddr;
  logic [31:0] cmd_data;
  logic        cmd_op;
  logic [15:0] sc_port;
  logic [31:0] sc_addr;
  logic [31:0] sc_subaddr;
  logic [31:0] sc_data;
  logic        sc_op;
  logic        sc_frame;
  logic        sc_wr;
  logic        sc_ack;
  logic [31:0] sc_rply_data;
  logic [31:0] sc_rply_error;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] rsp_error;
  logic        rsp_timeout;
  logic        busy;

  int vec_cnt;
  int err_cnt;

  // mode 1: responder acks whenever it is framed; otherwise ack_drv drives ack
  int   mode;
  logic ack_drv;
  assign sc_ack = (mode == 1) ? sc_frame : ack_drv;

  sc_cmd_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_port(cmd_port), .cmd_addr(cmd_addr), .cmd_subaddr(cmd_subaddr),
    .cmd_data(cmd_data), .cmd_op(cmd_op),
    .sc_port(sc_port), .sc_addr(sc_addr), .sc_subaddr(sc_subaddr),
    .sc_data(sc_data), .sc_op(sc_op), .sc_frame(sc_frame), .sc_wr(sc_wr),
    .sc_ack(sc_ack), .sc_rply_data(sc_rply_data), .sc_rply_error(sc_rply_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [15:0] p, input logic [31:0] a,
                          input logic [31:0] s, input logic [31:0] d, input logic o);
    cmd_port = p; cmd_addr = a; cmd_subaddr = s; cmd_data = d; cmd_op = o;
    cmd_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    vec_cnt++; if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec_cnt++; if ({sc_frame, sc_wr, rsp_valid, rsp_timeout} !== 4'b0) begin err_cnt++; $display("FAIL reset_strobes: got %b want 0000", {sc_frame, sc_wr, rsp_valid, rsp_timeout}); end
    vec_cnt++; if ({sc_port, sc_data, rsp_data, rsp_error} !== 112'h0) begin err_cnt++; $display("FAIL reset_fields: got %h want 0", {sc_port, sc_data, rsp_data, rsp_error}); end
  endtask

  task automatic test_write();
    send_cmd(16'h1797, 32'h0000_0010, 32'h0000_0002, 32'h0000_9C40, 1'b1);
    tick(); // accepted -> SETUP
    cmd_valid = 1'b0;
    vec_cnt++; if ({sc_frame, sc_wr, cmd_ready, busy} !== 4'b1001) begin err_cnt++; $display("FAIL wr_setup_ctl: got %b want 1001", {sc_frame, sc_wr, cmd_ready, busy}); end
    vec_cnt++; if ({sc_port, sc_addr, sc_subaddr, sc_data, sc_op} !== {16'h1797, 32'h10, 32'h2, 32'h9C40, 1'b1}) begin err_cnt++; $display("FAIL wr_fields: got %h want %h", {sc_port, sc_addr, sc_subaddr, sc_data, sc_op}, {16'h1797, 32'h10, 32'h2, 32'h9C40, 1'b1}); end
    tick(); // STROBE
    vec_cnt++; if ({sc_frame, sc_wr} !== 2'b11) begin err_cnt++; $display("FAIL wr_strobe: got %b want 11", {sc_frame, sc_wr}); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      vec_cnt++; if ({sc_frame, sc_wr, rsp_valid} !== 3'b100) begin err_cnt++; $display("FAIL wr_wait%0d: got %b want 100", i, {sc_frame, sc_wr, rsp_valid}); end
    end
    ack_drv = 1'b1; sc_rply_data = 32'hCAFE_0042; sc_rply_error = 32'h0;
    tick(); // RESP
    vec_cnt++; if ({rsp_valid, sc_frame, rsp_timeout} !== 3'b100) begin err_cnt++; $display("FAIL wr_resp_ctl: got %b want 100", {rsp_valid, sc_frame, rsp_timeout}); end
    vec_cnt++; if ({rsp_data, rsp_error} !== {32'hCAFE_0042, 32'h0}) begin err_cnt++; $display("FAIL wr_resp_data: got %h want cafe004200000000", {rsp_data, rsp_error}); end
    rsp_ready = 1'b1;
    tick(); // RELEASE
    rsp_ready = 1'b0;
    vec_cnt++; if ({rsp_valid, cmd_ready, busy} !== 3'b001) begin err_cnt++; $display("FAIL wr_release: got %b want 001", {rsp_valid, cmd_ready, busy}); end
    ack_drv = 1'b0;
    tick(); // IDLE
    vec_cnt++; if ({cmd_ready, busy} !== 2'b10) begin err_cnt++; $display("FAIL wr_idle: got %b want 10", {cmd_ready, busy}); end
  endtask

  task automatic test_unmapped();
    mode = 1; rsp_ready = 1'b1;
    sc_rply_data = 32'h0; sc_rply_error = 32'hFFFF_FFFF;
    send_cmd(16'h1234, 32'h0, 32'h5, 32'h0, 1'b0);
    tick(); // SETUP
    cmd_valid = 1'b0;
    tick(); // STROBE
    tick(); // WAIT_ACK, ack already high
    tick(); // RESP
    vec_cnt++; if ({rsp_valid, rsp_timeout} !== 2'b10) begin err_cnt++; $display("FAIL unm_resp_ctl: got %b want 10", {rsp_valid, rsp_timeout}); end
    vec_cnt++; if (rsp_error !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL unm_resp_err: got %h want ffffffff", rsp_error); end
    tick(); // RELEASE, ack dropped with frame
    vec_cnt++; if ({rsp_valid, busy} !== 2'b01) begin err_cnt++; $display("FAIL unm_release: got %b want 01", {rsp_valid, busy}); end
    tick(); // IDLE
    vec_cnt++; if ({cmd_ready, busy} !== 2'b10) begin err_cnt++; $display("FAIL unm_idle: got %b want 10", {cmd_ready, busy}); end
    mode = 0; rsp_ready = 1'b0;
  endtask

  task automatic test_silent();
    int n;
    ack_drv = 1'b0;
    sc_rply_data = 32'h5555_5555; sc_rply_error = 32'h1;
    send_cmd(16'h0042, 32'h1, 32'h1, 32'h1, 1'b0);
    tick(); // SETUP
    cmd_valid = 1'b0;
    tick(); // STROBE
    vec_cnt++; if (sc_wr !== 1'b1) begin err_cnt++; $display("FAIL sil_strobe: got %b want 1", sc_wr); end
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (rsp_valid === 1'b1) break;
    end
    vec_cnt++; if (n !== 17) begin err_cnt++; $display("FAIL sil_latency: got %0d want 17", n); end
    vec_cnt++; if ({rsp_timeout, sc_frame} !== 2'b10) begin err_cnt++; $display("FAIL sil_ctl: got %b want 10", {rsp_timeout, sc_frame}); end
    vec_cnt++; if ({rsp_data, rsp_error} !== {32'h0, 32'hFFFF_FFFF}) begin err_cnt++; $display("FAIL sil_fields: got %h want 00000000ffffffff", {rsp_data, rsp_error}); end
    rsp_ready = 1'b1;
    tick(); // RELEASE
    rsp_ready = 1'b0;
    tick(); // IDLE
    vec_cnt++; if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL sil_idle: got %b want 1", cmd_ready); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0; ack_drv = 1'b0;
    send_cmd(16'h0101, 32'h0, 32'h0, 32'h11, 1'b1);
    tick(); // SETUP
    cmd_valid = 1'b0;
    tick(); // STROBE
    ack_drv = 1'b1; sc_rply_data = 32'h1234_5678; sc_rply_error = 32'h5;
    tick(); // WAIT_ACK
    tick(); // RESP
    vec_cnt++; if (rsp_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_resp: got %b want 1", rsp_valid); end
    send_cmd(16'h00AA, 32'h0, 32'h0, 32'h22, 1'b0);
    sc_rply_data = 32'h0; sc_rply_error = 32'h0;
    for (int i = 0; i < 20; i++) begin
      tick();
      vec_cnt++; if ({cmd_ready, rsp_valid} !== 2'b01) begin err_cnt++; $display("FAIL bp_hold_ctl%0d: got %b want 01", i, {cmd_ready, rsp_valid}); end
      vec_cnt++; if ({rsp_data, rsp_error, sc_port} !== {32'h1234_5678, 32'h5, 16'h0101}) begin err_cnt++; $display("FAIL bp_hold_fields%0d: got %h want 12345678000000050101", i, {rsp_data, rsp_error, sc_port}); end
    end
    rsp_ready = 1'b1; ack_drv = 1'b0;
    tick(); // RELEASE
    rsp_ready = 1'b0;
    vec_cnt++; if ({rsp_valid, cmd_ready} !== 2'b00) begin err_cnt++; $display("FAIL bp_release: got %b want 00", {rsp_valid, cmd_ready}); end
    tick(); // IDLE, pending command about to be taken
    vec_cnt++; if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_idle: got %b want 1", cmd_ready); end
    tick(); // SETUP of second command
    cmd_valid = 1'b0;
    vec_cnt++; if ({sc_port, sc_data, sc_frame} !== {16'h00AA, 32'h22, 1'b1}) begin err_cnt++; $display("FAIL bp_next_cmd: got %h want 00aa000000221", {sc_port, sc_data, sc_frame}); end
    mode = 1; rsp_ready = 1'b1;
    tick(); tick(); tick(); tick(); tick(); // STROBE, WAIT, RESP, RELEASE, IDLE
    vec_cnt++; if ({cmd_ready, busy} !== 2'b10) begin err_cnt++; $display("FAIL bp_done: got %b want 10", {cmd_ready, busy}); end
    mode = 0; rsp_ready = 1'b0;
  endtask

  task automatic test_stuck_ack();
    int n;
    ack_drv = 1'b0;
    send_cmd(16'h0007, 32'h0, 32'h0, 32'h7, 1'b1);
    tick(); // SETUP
    cmd_valid = 1'b0;
    tick(); // STROBE
    ack_drv = 1'b1; sc_rply_data = 32'h0000_0033; sc_rply_error = 32'h0;
    tick(); // WAIT_ACK
    tick(); // RESP
    vec_cnt++; if ({rsp_valid, rsp_data} !== {1'b1, 32'h33}) begin err_cnt++; $display("FAIL stk_resp: got %h want 100000033", {rsp_valid, rsp_data}); end
    rsp_ready = 1'b1;
    tick(); // RELEASE cycle 1
    n = 0;
    while ((cmd_ready !== 1'b1) && (n < 40)) begin
      vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL stk_extra_rsp%0d: got %b want 0", n, rsp_valid); end
      tick();
      n++;
    end
    vec_cnt++; if (n !== 16) begin err_cnt++; $display("FAIL stk_release_len: got %0d want 16", n); end
    vec_cnt++; if ({busy, rsp_valid} !== 2'b00) begin err_cnt++; $display("FAIL stk_idle: got %b want 00", {busy, rsp_valid}); end
    ack_drv = 1'b0; rsp_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    ack_drv = 1'b0;
    send_cmd(16'h0009, 32'h0, 32'h0, 32'h9, 1'b1);
    tick(); // SETUP
    cmd_valid = 1'b0;
    tick(); // STROBE
    tick(); // WAIT_ACK
    vec_cnt++; if ({sc_frame, sc_wr} !== 2'b10) begin err_cnt++; $display("FAIL rmid_wait: got %b want 10", {sc_frame, sc_wr}); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec_cnt++; if ({sc_frame, sc_wr, rsp_valid, cmd_ready, busy} !== 5'b00010) begin err_cnt++; $display("FAIL rmid_after: got %b want 00010", {sc_frame, sc_wr, rsp_valid, cmd_ready, busy}); end
    ack_drv = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vec_cnt++; if ({rsp_valid, busy} !== 2'b00) begin err_cnt++; $display("FAIL rmid_no_rsp%0d: got %b want 00", i, {rsp_valid, busy}); end
    end
    ack_drv = 1'b0; rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int wr_first, wr_second, wr_n;
    logic [31:0] data_at_second;
    mode = 1; rsp_ready = 1'b1;
    wr_first = -1; wr_second = -1; wr_n = 0; data_at_second = 32'h0;
    send_cmd(16'h0010, 32'h0, 32'h0, 32'hAAAA_0001, 1'b1);
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (t == 1) cmd_data = 32'hBBBB_0002;
      if (t == 7) cmd_valid = 1'b0;
      if (sc_wr === 1'b1) begin
        wr_n++;
        if (wr_first < 0) wr_first = t;
        else if (wr_second < 0) begin wr_second = t; data_at_second = sc_data; end
      end
    end
    vec_cnt++; if (wr_first !== 2) begin err_cnt++; $display("FAIL b2b_first_wr: got %0d want 2", wr_first); end
    vec_cnt++; if (wr_second !== 8) begin err_cnt++; $display("FAIL b2b_second_wr: got %0d want 8", wr_second); end
    vec_cnt++; if (wr_n !== 2) begin err_cnt++; $display("FAIL b2b_wr_count: got %0d want 2", wr_n); end
    vec_cnt++; if (data_at_second !== 32'hBBBB_0002) begin err_cnt++; $display("FAIL b2b_second_data: got %h want bbbb0002", data_at_second); end
    mode = 0; rsp_ready = 1'b0;
  endtask

  initial begin
    vec_cnt = 0; err_cnt = 0;
    mode = 0; ack_drv = 1'b0; rst = 1'b1;
    cmd_valid = 1'b0; cmd_port = '0; cmd_addr = '0; cmd_subaddr = '0; cmd_data = '0; cmd_op = 1'b0;
    sc_rply_data = '0; sc_rply_error = '0; rsp_ready = 1'b0;
    test_reset();
    test_write();
    test_unmapped();
    test_silent();
    test_backpressure();
    test_stuck_ack();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sc_cmd_initiator.md
# sc_cmd_initiator

Initiator (master) end of the slow-control (SC) bus that the application responders hang off. The block accepts one command at a time from an upstream command source, such as the UDP command decoder, over a valid/ready interface. It runs a single SC transaction per command: frame, write strobe, wait for ack, release. It returns the responder's reply data and error word, or a timeout, over a valid/ready response interface.

## Interface
- `TIMEOUT_CYCLES`, default 4096: clock cycles allowed for ack assertion, and separately for ack release, before abort.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake; transfer when both are high.
- `cmd_port` in 16, `cmd_addr` in 32, `cmd_subaddr` in 32, `cmd_data` in 32, `cmd_op` in 1: command fields.
- `sc_port` out 16, `sc_addr` out 32, `sc_subaddr` out 32, `sc_data` out 32, `sc_op` out 1: SC bus fields.
- `sc_frame` out 1, `sc_wr` out 1: SC bus framing and write strobe.
- `sc_ack` in 1, `sc_rply_data` in 32, `sc_rply_error` in 32: responder reply.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_data` out 32, `rsp_error` out 32, `rsp_timeout` out 1: response fields.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **Reset values:** all outputs 0 except `cmd_ready`=1. State is IDLE and the counter is 0.
- **IDLE:** `cmd_ready`=1. On a command handshake, register all fields onto the `sc_*` field outputs and go to SETUP. `cmd_ready`=0 in every other state.
- **SETUP (1 cycle):** `sc_frame`=1 and the fields are stable. Go to STROBE.
- **STROBE (1 cycle):** `sc_wr`=1 and `sc_frame`=1. Clear the counter. Go to WAIT_ACK.
- **WAIT_ACK:** `sc_frame`=1 and `sc_wr`=0.
  - `sc_ack` is sampled as a level.
  - If `sc_ack`=1, capture `sc_rply_data` into `rsp_data` and `sc_rply_error` into `rsp_error`, set `rsp_timeout`=0, and go to RESP.
  - If instead the counter reaches `TIMEOUT_CYCLES`-1 with no ack, set `rsp_data`=0, `rsp_error`=32'hFFFFFFFF, `rsp_timeout`=1, and go to RESP.
  - Otherwise increment the counter.
- **RESP:**
  - `sc_frame`=0. The field outputs hold their values.
  - `rsp_valid`=1, and the response fields are stable until the handshake.
  - On `rsp_ready`=1, clear `rsp_valid`, clear the counter, and go to RELEASE.
- **RELEASE:**
  - `sc_frame`=0.
  - When `sc_ack`=0, go to IDLE.
  - If the counter reaches `TIMEOUT_CYCLES`-1 first, go to IDLE anyway. No second response is generated, and the stuck ack is ignored.
- The field outputs are updated only on command acceptance. They are never zeroed after reset.
- Any `sc_rply_error` value, including FFFFFFFF from an unmapped port, is passed through unchanged. The block never interprets it.
- `sc_ack` that is already high at STROBE is accepted in the first WAIT_ACK cycle.
- The counter is `$clog2(TIMEOUT_CYCLES)` bits wide and saturates; it never wraps.

## Timing
- **Command to bus:** the handshake at cycle N gives `sc_frame`=1 at N+1 and `sc_wr`=1 at N+2. The earliest ack sample is at N+3.
- **Ack to response:** `sc_ack` sampled high at cycle M gives `rsp_valid`=1 at M+1 and `sc_frame`=0 at M+1.
- **Timeout:** if no ack arrives, `rsp_valid` rises exactly `TIMEOUT_CYCLES`+1 cycles after the `sc_wr` cycle.
- **Throughput:** minimum of 6 cycles per command, with an immediate ack, `rsp_ready` held high, and ack dropping with frame.
- **`rsp_ready` low:** RESP holds indefinitely; there is no timeout in RESP.
- **`rst` mid-transaction:** outputs and state return to reset values on the next edge. `sc_frame` and `sc_wr` drop in that same edge, and the in-flight command is discarded without a response.

## Structure
- Shared package `sc_bus_pkg` holds:
  - the state enum (IDLE, SETUP, STROBE, WAIT_ACK, RESP, RELEASE);
  - `SC_ERR_TIMEOUT`=32'hFFFFFFFF;
  - the SC field widths (port 16, addr/subaddr/data/error 32).
- There are no sub-modules. A single FSM plus the timeout counter lives in one module.

## Test plan
- **Write to gen-app port:** command port 16'h1797, subaddr 2, data 32'h00009C40, op 1. The responder acks 3 cycles after `sc_wr`. Required: one `sc_wr` pulse, then a response with `rsp_data` and `rsp_error`=0 as the responder drives them, and `rsp_timeout`=0.
- **Unmapped port:** command port 16'h1234 with a model where `sc_ack`=`sc_frame`. Required: ack in the first WAIT_ACK cycle, `rsp_error`=FFFFFFFF, `rsp_timeout`=0, return to IDLE the cycle after the response.
- **Silent responder:** `TIMEOUT_CYCLES`=16. Required: `rsp_valid` exactly 17 cycles after `sc_wr`, `rsp_timeout`=1, `rsp_error`=FFFFFFFF, `rsp_data`=0.
- **Backpressure:** `rsp_ready` held low for 20 cycles with a new `cmd_valid` pending. Required: `cmd_ready`=0 and the response fields stable throughout; the next command is accepted only after release.
- **Stuck ack:** `sc_ack` held high after the response. Required: exit RELEASE after `TIMEOUT_CYCLES` cycles with no extra `rsp_valid`.
- **Reset in WAIT_ACK:** assert `rst` for 1 cycle. Required: `sc_frame`, `sc_wr` and `rsp_valid`=0 at the next edge, and `cmd_ready`=1.
